wei_buf: RTL and testbench

Weight buffer: a single-port register-array store of weights that answers the weight cache arbiter's read requests. TOP first streams weights into it, then switches it to serve mode. In serve mode it is the responder on the WCA↔WBF address/data handshake: it accepts one read address per handshake and returns one registered data word per address, in order. It sits between TOP's weight-load path and WCA.

---
 rtl/wbf_pkg.sv | 13 +
 rtl/wbf_ram.sv | 32 +++
 rtl/wei_buf.sv | 116 +++++++++++
 tb/tb_wei_buf.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wbf_pkg.sv
// Shared definitions for the weight buffer: config opcodes and controller states.
package wbf_pkg;

    localparam logic [1:0] ISA_LOAD  = 2'b00;
    localparam logic [1:0] ISA_SERVE = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } wbfState_e;

endpackage

// File: rtl/wbf_ram.sv
// Single-port weight array: synchronous write and registered read on a shared address.
module wbf_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wrEn,
    input  logic                  rdEn,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] wrDat,
    output logic [DATA_WIDTH-1:0] rdDat
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset so it maps onto RAM macros; only the read register clears.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[adr] <= wrDat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdDat <= '0;
        end else if (rdEn) begin
            rdDat <= mem[adr];
        end
    end

endmodule

// File: rtl/wei_buf.sv
// Weight buffer: TOP streams weights in (LOAD), then WCA reads them back by address (SERVE).
module wei_buf
    import wbf_pkg::*;
#(
    parameter int ISA_WIDTH      = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int WEI_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      TOPWBF_CfgVld,
    input  logic [ISA_WIDTH-1:0]      TOPWBF_CfgISA,
    input  logic [WEI_ADDR_WIDTH-1:0] TOPWBF_CfgNum,
    output logic                      WBFTOP_CfgRdy,
    input  logic                      TOPWBF_DatVld,
    input  logic [DATA_WIDTH-1:0]     TOPWBF_Dat,
    output logic                      WBFTOP_DatRdy,
    input  logic                      WCAWBF_AdrVld,
    input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
    output logic                      WBFWCA_AdrRdy,
    output logic                      WBFWCA_DatVld,
    output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
    input  logic                      WCAWBF_DatRdy
);

    localparam logic [WEI_ADDR_WIDTH:0] CNT_ONE = 1;

    wbfState_e                 state;
    logic [WEI_ADDR_WIDTH-1:0] numQ;
    logic [WEI_ADDR_WIDTH-1:0] wrCnt;
    logic [WEI_ADDR_WIDTH:0]   rdCnt;
    logic                      datVld;

    logic                      topHs;
    logic                      adrHs;
    logic                      rdHs;
    logic                      outFree;
    logic                      serveDone;
    logic [WEI_ADDR_WIDTH:0]   numExt;
    logic [WEI_ADDR_WIDTH-1:0] ramAdr;

    assign numExt  = {1'b0, numQ};
    // The output slot can take a new word when it is empty or being drained this cycle.
    assign outFree = !datVld || WCAWBF_DatRdy;

    assign WBFTOP_CfgRdy = (state == IDLE);
    assign WBFTOP_DatRdy = (state == LOAD);
    assign WBFWCA_AdrRdy = (state == SERVE) && (rdCnt <= numExt) && outFree;
    assign WBFWCA_DatVld = datVld;

    assign topHs     = TOPWBF_DatVld && WBFTOP_DatRdy;
    assign adrHs     = WCAWBF_AdrVld && WBFWCA_AdrRdy;
    assign rdHs      = datVld && WCAWBF_DatRdy;
    assign serveDone = (state == SERVE) && (rdCnt == numExt + CNT_ONE) && outFree;
    assign ramAdr    = (state == LOAD) ? wrCnt : WCAWBF_Adr;

    // NOTE: all state below uses <= so every register samples pre-edge values in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            numQ   <= '0;
            wrCnt  <= '0;
            rdCnt  <= '0;
            datVld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (TOPWBF_CfgVld) begin
                        numQ  <= TOPWBF_CfgNum;
                        wrCnt <= '0;
                        rdCnt <= '0;
                        if (TOPWBF_CfgISA == ISA_WIDTH'(ISA_LOAD)) begin
                            state <= LOAD;
                        end else if (TOPWBF_CfgISA == ISA_WIDTH'(ISA_SERVE)) begin
                            state <= SERVE;
                        end
                    end
                end
                LOAD: begin
                    if (topHs) begin
                        wrCnt <= wrCnt + 1'b1;
                        if (wrCnt == numQ) begin
                            state <= IDLE;
                        end
                    end
                end
                SERVE: begin
                    if (adrHs) begin
                        rdCnt  <= rdCnt + 1'b1;
                        datVld <= 1'b1;
                    end else if (rdHs) begin
                        datVld <= 1'b0;
                    end
                    if (serveDone) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wbf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (WEI_ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .wrEn  (topHs),
        .rdEn  (adrHs),
        .adr   (ramAdr),
        .wrDat (TOPWBF_Dat),
        .rdDat (WBFWCA_Dat)
    );

endmodule

// File: tb/tb_wei_buf.sv
// Randomized self-checking bench for wei_buf against a queue/array reference model.
module tb_wei_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfgVld;
    logic [1:0] cfgIsa;
    logic [7:0] cfgNum;
    logic       cfgRdy;
    logic       topVld;
    logic [7:0] topDat;
    logic       topRdy;
    logic       adrVld;
    logic [7:0] adr;
    logic       adrRdy;
    logic       datVld;
    logic [7:0] dat;
    logic       datRdy;

    int         nVec = 0;
    int         nErr = 0;

    logic [7:0] refMem [256];
    int         adrList [256];
    logic [7:0] expQ [$];

    always #5 clk = ~clk;

    wei_buf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .TOPWBF_CfgVld (cfgVld),
        .TOPWBF_CfgISA (cfgIsa),
        .TOPWBF_CfgNum (cfgNum),
        .WBFTOP_CfgRdy (cfgRdy),
        .TOPWBF_DatVld (topVld),
        .TOPWBF_Dat    (topDat),
        .WBFTOP_DatRdy (topRdy),
        .WCAWBF_AdrVld (adrVld),
        .WCAWBF_Adr    (adr),
        .WBFWCA_AdrRdy (adrRdy),
        .WBFWCA_DatVld (datVld),
        .WBFWCA_Dat    (dat),
        .WCAWBF_DatRdy (datRdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] wordFor(input int mode, input int i);
        if (mode == 0) return 8'((i + 1) * 8'h11);
        return 8'(i) ^ 8'hA5;
    endfunction

    task automatic idleOutputs(input string tag);
        chk({tag, ".cfgRdy"}, cfgRdy, 1'b1);
        chk({tag, ".topRdy"}, topRdy, 1'b0);
        chk({tag, ".adrRdy"}, adrRdy, 1'b0);
        chk({tag, ".datVld"}, datVld, 1'b0);
    endtask

    task automatic cfg(input logic [1:0] isa, input int num);
        @(negedge clk);
        cfgVld = 1'b1;
        cfgIsa = isa;
        cfgNum = 8'(num);
        #1;
        chk("cfg.rdy", cfgRdy, 1'b1);
        @(posedge clk);
        #1;
        cfgVld = 1'b0;
    endtask

    task automatic loadWords(input int num, input int mode, input int vldPct);
        int idx = 0;
        int cyc = 0;
        cfg(2'b00, num);
        while (idx <= num && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            topVld = ($urandom_range(99) < vldPct);
            topDat = wordFor(mode, idx);
            #1;
            chk("load.topRdy", topRdy, 1'b1);
            if (topVld) begin
                refMem[idx] = topDat;
                idx++;
            end
        end
        if (idx <= num) chk("load.timeout", 0, 1);
        @(posedge clk);
        #1;
        topVld = 1'b0;
        @(negedge clk);
        idleOutputs("loadEnd");
    endtask

    task automatic serve(input int num, input int rdyPct, input int vldPct);
        int   issued = 0;
        int   cyc = 0;
        logic expVld;
        logic expAdrRdy;
        expQ.delete();
        cfg(2'b01, num);
        while ((issued <= num || expQ.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            adrVld = (issued <= num) && ($urandom_range(99) < vldPct);
            adr    = (issued <= num) ? 8'(adrList[issued]) : 8'h00;
            datRdy = ($urandom_range(99) < rdyPct);
            #1;
            expVld = (expQ.size() != 0);
            chk("serve.datVld", datVld, expVld);
            if (expVld) chk("serve.dat", dat, expQ[0]);
            expAdrRdy = (issued <= num) && (!expVld || datRdy);
            chk("serve.adrRdy", adrRdy, expAdrRdy);
            if (expVld && datRdy) void'(expQ.pop_front());
            if (adrVld && expAdrRdy) begin
                expQ.push_back(refMem[adrList[issued]]);
                issued++;
            end
        end
        if (cyc >= 4000) chk("serve.timeout", 0, 1);
        @(posedge clk);
        #1;
        adrVld = 1'b0;
        datRdy = 1'b0;
        @(negedge clk);
        idleOutputs("serveEnd");
    endtask

    initial begin
        rst_n  = 1'b0;
        cfgVld = 1'b0;
        cfgIsa = 2'b00;
        cfgNum = 8'h00;
        topVld = 1'b0;
        topDat = 8'h00;
        adrVld = 1'b0;
        adr    = 8'h00;
        datRdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idleOutputs("reset");
        chk("reset.dat", dat, 8'h00);

        // Four-word load with toggling valid, then full-rate reads in scrambled order.
        loadWords(3, 0, 50);
        adrList[0] = 3; adrList[1] = 0; adrList[2] = 2; adrList[3] = 1;
        serve(3, 100, 100);

        // Backpressure: repeated reads of the four loaded words.
        for (int i = 0; i < 16; i++) adrList[i] = $urandom_range(3);
        serve(15, 50, 80);

        // Full depth load and a shuffled full read-back.
        loadWords(255, 1, 75);
        for (int i = 0; i < 256; i++) adrList[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j = $urandom_range(i);
            int t = adrList[i];
            adrList[i] = adrList[j];
            adrList[j] = t;
        end
        serve(255, 50, 90);

        // NOP opcodes and stray valids in IDLE get no handshake.
        cfg(2'b10, 5);
        cfg(2'b11, 9);
        repeat (3) begin
            @(negedge clk);
            adrVld = 1'b1;
            topVld = 1'b1;
            adr    = 8'h07;
            topDat = 8'hEE;
            #1;
            idleOutputs("nop");
        end
        @(negedge clk);
        adrVld = 1'b0;
        topVld = 1'b0;

        // Reset while a read word is pending.
        cfg(2'b01, 3);
        @(negedge clk);
        adrVld = 1'b1;
        adr    = 8'h01;
        datRdy = 1'b0;
        #1;
        chk("rstServe.adrRdy", adrRdy, 1'b1);
        @(negedge clk);
        adrVld = 1'b0;
        #1;
        chk("rstServe.datVld", datVld, 1'b1);
        chk("rstServe.dat", dat, refMem[1]);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        idleOutputs("rstServe");
        chk("rstServe.dat0", dat, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        adrList[0] = 2;
        serve(0, 100, 100);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
